// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: register map, FSM state encoding and helpers shared by the
// interrupt controller and its priority encoder.
package irq_ctrl_pkg;

   // Width of the source index carried on irq_vec and in the STAT register.
   localparam int VEC_W = 3;

   // Register map on the shared 16-bit peripheral bus.
   localparam logic [15:0] ADDR_IRQ_PEND = 16'h0040;
   localparam logic [15:0] ADDR_IRQ_EN   = 16'h0041;
   localparam logic [15:0] ADDR_IRQ_STAT = 16'h0042;
   localparam logic [15:0] ADDR_IRQ_EOI  = 16'h0043;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_INSVC = 2'd2
   } irq_state_e;

   // Byte mask with one bit set for each implemented source.
   function automatic logic [7:0] src_mask(input int num_src);
      logic [7:0] m;
      m = 8'h00;
      for (int i = 0; i < 8; i++) begin
         m[i] = (i < num_src) ? 1'b1 : 1'b0;
      end
      return m;
   endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational fixed-priority encoder, lowest index wins.
module irq_prio_enc
   import irq_ctrl_pkg::*;
#(
   parameter int NUM_SRC = 8
) (
   input  logic [NUM_SRC-1:0] req,
   output logic               valid,
   output logic [VEC_W-1:0]   idx
);

   // Scan from the top down so the lowest set index is the last one kept.
   always_comb begin
      valid = 1'b0;
      idx   = {VEC_W{1'b0}};
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         valid = valid | req[i];
         idx   = req[i] ? VEC_W'(i) : idx;
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller. Latches source events into
// pending bits, masks them with an enable register and runs a
// request / ack / EOI handshake towards the CPU.
// Build option: define IRQ_EDGE_DETECT_EN to set pending bits only on rising
// source edges; by default sources are level-sensitive.
// The read-data port is named dout because 'do' is a reserved word.
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int NUM_SRC = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [15:0]        addr,
   input  logic               we,
   input  logic [7:0]         di,
   output logic [7:0]         dout,
   input  logic [NUM_SRC-1:0] src,
   output logic               irq,
   output logic [2:0]         irq_vec,
   input  logic               irq_ack
);

   localparam logic [7:0] SRC_MASK = src_mask(NUM_SRC);

   irq_state_e state_r;
   irq_state_e state_nxt_s;
   logic [7:0] pending_r;
   logic [7:0] pending_nxt_s;
   logic [7:0] enable_r;
   logic [7:0] set_s;
   logic [7:0] clr_s;
   logic [7:0] active_s;
   logic       irq_r;
   logic       irq_nxt_s;
   logic [2:0] vec_r;
   logic [2:0] vec_nxt_s;
   logic       win_valid_s;
   logic [2:0] win_idx_s;
   logic       pend_wr_s;
   logic       en_wr_s;
   logic       eoi_wr_s;
   logic       ack_s;
   logic       in_svc_s;

`ifdef IRQ_EDGE_DETECT_EN
   logic [NUM_SRC-1:0] src_q_r;

   // Last cycle's source levels, so a held level only fires once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         src_q_r <= {NUM_SRC{1'b0}};
      end else begin
         src_q_r <= src;
      end
   end

   assign set_s = 8'(src & ~src_q_r);
`else
   assign set_s = 8'(src);
`endif

   assign pend_wr_s = we && (addr == ADDR_IRQ_PEND);
   assign en_wr_s   = we && (addr == ADDR_IRQ_EN);
   assign eoi_wr_s  = we && (addr == ADDR_IRQ_EOI) && (state_r == S_INSVC);
   assign ack_s     = irq_ack && (state_r == S_REQ);
   assign in_svc_s  = (state_r == S_INSVC);

   // Clears are applied before sets so a new event on the same bit survives.
   assign clr_s         = (pend_wr_s ? di : 8'h00) | (ack_s ? (8'h01 << vec_r) : 8'h00);
   assign pending_nxt_s = ((pending_r & ~clr_s) | set_s) & SRC_MASK;
   assign active_s      = pending_r & enable_r;

   irq_prio_enc #(
      .NUM_SRC (NUM_SRC)
   ) u_prio (
      .req   (active_s[NUM_SRC-1:0]),
      .valid (win_valid_s),
      .idx   (win_idx_s)
   );

   // Pending/enable registers, FSM state and the registered request outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_r <= 8'h00;
         enable_r  <= 8'h00;
         state_r   <= S_IDLE;
         irq_r     <= 1'b0;
         vec_r     <= 3'd0;
      end else begin
         pending_r <= pending_nxt_s;
         enable_r  <= en_wr_s ? (di & SRC_MASK) : enable_r;
         state_r   <= state_nxt_s;
         irq_r     <= irq_nxt_s;
         vec_r     <= vec_nxt_s;
      end
   end

   // Handshake FSM: the vector is latched on entry to S_REQ and held until ack.
   always_comb begin
      state_nxt_s = state_r;
      irq_nxt_s   = irq_r;
      vec_nxt_s   = vec_r;
      case (state_r)
         S_IDLE: begin
            if (win_valid_s) begin
               state_nxt_s = S_REQ;
               irq_nxt_s   = 1'b1;
               vec_nxt_s   = win_idx_s;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_REQ: begin
            if (ack_s) begin
               state_nxt_s = S_INSVC;
               irq_nxt_s   = 1'b0;
            end else begin
               state_nxt_s = S_REQ;
            end
         end
         S_INSVC: begin
            if (eoi_wr_s) begin
               state_nxt_s = S_IDLE;
            end else begin
               state_nxt_s = S_INSVC;
            end
         end
         default: begin
            state_nxt_s = S_IDLE;
            irq_nxt_s   = 1'b0;
            vec_nxt_s   = 3'd0;
         end
      endcase
   end

   // Combinational read mux; unmapped and write-only addresses read zero.
   always_comb begin
      dout = 8'h00;
      case (addr)
         ADDR_IRQ_PEND: dout = pending_r;
         ADDR_IRQ_EN:   dout = enable_r;
         ADDR_IRQ_STAT: dout = {in_svc_s, irq_r, 3'b000, vec_r};
         default:       dout = 8'h00;
      endcase
   end

   assign irq     = irq_r;
   assign irq_vec = vec_r;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: table-driven bench for irq_ctrl with an expectation queue.
module tb_irq_ctrl;
   import irq_ctrl_pkg::*;

   localparam logic [15:0] A_PEND = ADDR_IRQ_PEND;
   localparam logic [15:0] A_EN   = ADDR_IRQ_EN;
   localparam logic [15:0] A_STAT = ADDR_IRQ_STAT;
   localparam logic [15:0] A_EOI  = ADDR_IRQ_EOI;
   localparam logic [7:0]  M      = 8'hFF;
   localparam logic [7:0]  MS     = 8'hF8;
`ifdef IRQ_EDGE_DETECT_EN
   localparam logic [7:0]  T4_EXP = 8'h00;
`else
   localparam logic [7:0]  T4_EXP = 8'h01;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] addr = 16'h0000;
   logic        we = 1'b0;
   logic [7:0]  di = 8'h00;
   logic [7:0]  dout;
   logic [7:0]  src = 8'h00;
   logic        irq;
   logic [2:0]  irq_vec;
   logic        irq_ack = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   irq_ctrl #(.NUM_SRC(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .addr    (addr),
      .we      (we),
      .di      (di),
      .dout    (dout),
      .src     (src),
      .irq     (irq),
      .irq_vec (irq_vec),
      .irq_ack (irq_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       irq;
      logic [2:0] vec;
      logic [7:0] dout;
      logic [7:0] dmask;
   } exp_t;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [7:0]  di;
      logic [7:0]  src;
      logic        ack;
      logic        irq;
      logic [2:0]  vec;
      logic [7:0]  dout;
      logic [7:0]  dmask;
   } vec_t;

   exp_t sb_q[$];
   vec_t tbl[$];

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h want %02h", nm, act, exp);
      end
   endtask

   task automatic sb_check();
      exp_t e;
      if (sb_q.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL scoreboard: queue empty, got irq=%0b want an entry", irq);
      end else begin
         e = sb_q.pop_front();
         check({e.name, ".irq"}, {7'd0, irq}, {7'd0, e.irq});
         if (e.irq) check({e.name, ".vec"}, {5'd0, irq_vec}, {5'd0, e.vec});
         check({e.name, ".do"}, dout & e.dmask, e.dout & e.dmask);
      end
   endtask

   // One clock: drive inputs, queue expected outputs, compare after the edge.
   task automatic cyc(input logic w, input logic [15:0] a, input logic [7:0] d,
                      input logic [7:0] s, input logic k, input logic e_irq,
                      input logic [2:0] e_vec, input logic [7:0] e_do,
                      input logic [7:0] m, input string nm);
      exp_t e;
      we = w; addr = a; di = d; src = s; irq_ack = k;
      e.name = nm; e.irq = e_irq; e.vec = e_vec; e.dout = e_do; e.dmask = m;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      sb_check();
   endtask

   task automatic add(input logic w, input logic [15:0] a, input logic [7:0] d,
                      input logic [7:0] s, input logic k, input logic e_irq,
                      input logic [2:0] e_vec, input logic [7:0] e_do, input logic [7:0] m);
      vec_t v;
      v.we = w; v.addr = a; v.di = d; v.src = s; v.ack = k;
      v.irq = e_irq; v.vec = e_vec; v.dout = e_do; v.dmask = m;
      tbl.push_back(v);
   endtask

   initial begin
      // Reset values.
      #1 rst = 1'b1;
      #2;
      addr = A_PEND; #1 check("rst.pend", dout, 8'h00);
      addr = A_EN;   #1 check("rst.en", dout, 8'h00);
      addr = A_STAT; #1 check("rst.stat", dout, 8'h00);
      addr = 16'h1234; #1 check("rst.unmapped", dout, 8'h00);
      check("rst.irq", {7'd0, irq}, 8'h00);
      check("rst.vec", {5'd0, irq_vec}, 8'h00);
      @(posedge clk); #1 rst = 1'b0;

      // Test 1: single source, latency, ack, EOI.
      add(1'b1, A_EN,   8'h01, 8'h00, 1'b0, 1'b0, 3'd0, 8'h01, M);
      add(1'b0, A_PEND, 8'h00, 8'h01, 1'b0, 1'b0, 3'd0, 8'h01, M);
      add(1'b0, A_STAT, 8'h00, 8'h00, 1'b0, 1'b1, 3'd0, 8'h40, M);
      add(1'b0, A_PEND, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, M);
      add(1'b0, A_STAT, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h80, MS);
      add(1'b1, A_EOI,  8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, M);
      add(1'b0, A_STAT, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, MS);
      // Test 2: two simultaneous sources, second follows one cycle after EOI.
      add(1'b1, A_EN,   8'hFF, 8'h00, 1'b0, 1'b0, 3'd0, 8'hFF, M);
      add(1'b0, A_PEND, 8'h00, 8'h0C, 1'b0, 1'b0, 3'd0, 8'h0C, M);
      add(1'b0, A_STAT, 8'h00, 8'h00, 1'b0, 1'b1, 3'd2, 8'h42, M);
      add(1'b0, A_PEND, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h08, M);
      add(1'b1, A_EOI,  8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, M);
      add(1'b0, A_STAT, 8'h00, 8'h00, 1'b0, 1'b1, 3'd3, 8'h43, M);
      add(1'b0, A_PEND, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, M);
      add(1'b1, A_EOI,  8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, M);
      // Test 3: no preemption; masking and W1C do not withdraw the request.
      add(1'b0, A_PEND, 8'h00, 8'h20, 1'b0, 1'b0, 3'd0, 8'h20, M);
      add(1'b0, A_STAT, 8'h00, 8'h00, 1'b0, 1'b1, 3'd5, 8'h45, M);
      add(1'b0, A_PEND, 8'h00, 8'h02, 1'b0, 1'b1, 3'd5, 8'h22, M);
      add(1'b0, A_STAT, 8'h00, 8'h00, 1'b0, 1'b1, 3'd5, 8'h45, M);
      add(1'b0, A_PEND, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h02, M);
      add(1'b1, A_EOI,  8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, M);
      add(1'b0, A_STAT, 8'h00, 8'h00, 1'b0, 1'b1, 3'd1, 8'h41, M);
      add(1'b1, A_EN,   8'h00, 8'h00, 1'b0, 1'b1, 3'd1, 8'h00, M);
      add(1'b1, A_PEND, 8'h02, 8'h00, 1'b0, 1'b1, 3'd1, 8'h00, M);
      add(1'b0, A_PEND, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, M);
      add(1'b1, A_EOI,  8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, M);
      add(1'b1, A_EN,   8'hFF, 8'h00, 1'b0, 1'b0, 3'd0, 8'hFF, M);
      // Test 5b: ack in S_IDLE, EOI in S_REQ, no request while in service.
      add(1'b0, A_STAT, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, MS);
      add(1'b0, A_PEND, 8'h00, 8'h10, 1'b0, 1'b0, 3'd0, 8'h10, M);
      add(1'b0, A_STAT, 8'h00, 8'h00, 1'b0, 1'b1, 3'd4, 8'h44, M);
      add(1'b1, A_EOI,  8'h00, 8'h00, 1'b0, 1'b1, 3'd4, 8'h00, M);
      add(1'b0, A_STAT, 8'h00, 8'h00, 1'b0, 1'b1, 3'd4, 8'h44, M);
      add(1'b0, A_PEND, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, M);
      add(1'b0, A_STAT, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h80, MS);
      add(1'b0, A_PEND, 8'h00, 8'h08, 1'b0, 1'b0, 3'd0, 8'h08, M);
      add(1'b0, A_STAT, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h80, MS);
      add(1'b1, A_EOI,  8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, M);
      add(1'b0, A_STAT, 8'h00, 8'h00, 1'b0, 1'b1, 3'd3, 8'h43, M);
      add(1'b0, A_PEND, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, M);
      add(1'b1, A_EOI,  8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, M);
      // Test 5a: set beats W1C and ack-clear on the same bit.
      add(1'b1, A_PEND, 8'h04, 8'h04, 1'b0, 1'b0, 3'd0, 8'h04, M);
      add(1'b0, A_PEND, 8'h00, 8'h00, 1'b0, 1'b1, 3'd2, 8'h04, M);
      add(1'b0, A_PEND, 8'h00, 8'h04, 1'b1, 1'b0, 3'd0, 8'h04, M);
      add(1'b1, A_PEND, 8'h04, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, M);
      add(1'b1, A_EOI,  8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, M);
      add(1'b0, A_STAT, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, MS);

      foreach (tbl[i]) begin
         cyc(tbl[i].we, tbl[i].addr, tbl[i].di, tbl[i].src, tbl[i].ack,
             tbl[i].irq, tbl[i].vec, tbl[i].dout, tbl[i].dmask, $sformatf("v%0d", i));
      end

      // Test 4: src[0] held high for 100 cycles, W1C in the middle.
      cyc(1'b1, A_EN,   8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, M, "t4.en0");
      cyc(1'b0, A_PEND, 8'h00, 8'h01, 1'b0, 1'b0, 3'd0, 8'h01, M, "t4.set");
      for (int i = 0; i < 48; i++) begin
         @(posedge clk); #1;
      end
      cyc(1'b1, A_PEND, 8'h01, 8'h01, 1'b0, 1'b0, 3'd0, T4_EXP, M, "t4.w1c");
      we = 1'b0;
      for (int i = 0; i < 49; i++) begin
         @(posedge clk); #1;
      end
      cyc(1'b0, A_PEND, 8'h00, 8'h01, 1'b0, 1'b0, 3'd0, T4_EXP, M, "t4.hold");
      cyc(1'b1, A_PEND, 8'h01, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, M, "t4.clr");

      // Test 6: asynchronous reset while a request is outstanding.
      cyc(1'b1, A_EN,   8'hFF, 8'h00, 1'b0, 1'b0, 3'd0, 8'hFF, M, "t6.en");
      cyc(1'b0, A_PEND, 8'h00, 8'h01, 1'b0, 1'b0, 3'd0, 8'h01, M, "t6.set");
      cyc(1'b0, A_STAT, 8'h00, 8'h00, 1'b0, 1'b1, 3'd0, 8'h40, M, "t6.req");
      src = 8'h20;
      irq_ack = 1'b0;
      we = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("t6.irq", {7'd0, irq}, 8'h00);
      check("t6.vec", {5'd0, irq_vec}, 8'h00);
      addr = A_PEND; #1 check("t6.pend", dout, 8'h00);
      addr = A_EN;   #1 check("t6.en0", dout, 8'h00);
      addr = A_STAT; #1 check("t6.stat", dout, 8'h00);
      src = 8'h00;
      @(posedge clk); #1 rst = 1'b0;
      cyc(1'b0, A_STAT, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, M, "t6.idle");
      cyc(1'b1, A_EN,   8'h01, 8'h00, 1'b0, 1'b0, 3'd0, 8'h01, M, "t6.en1");
      cyc(1'b0, A_PEND, 8'h00, 8'h01, 1'b0, 1'b0, 3'd0, 8'h01, M, "t6.set2");
      cyc(1'b0, A_STAT, 8'h00, 8'h00, 1'b0, 1'b1, 3'd0, 8'h40, M, "t6.req2");
      cyc(1'b0, A_PEND, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, M, "t6.ack");
      cyc(1'b1, A_EOI,  8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, M, "t6.eoi");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
